// File: rtl/snn_pkg.sv
// Shared types, width helpers and the membrane clamp for the LIF layer.
// Default layer geometry lives here so every file agrees on it.
package snn_pkg;

  localparam int SNN_N_IN         = 3;
  localparam int SNN_N_OUT        = 2;
  localparam int SNN_W_WIDTH      = 4;
  localparam int SNN_V_WIDTH      = 8;
  localparam int SNN_THRESH       = 100;
  localparam int SNN_LEAK_SHIFT   = 3;
  localparam int SNN_REFRAC_TICKS = 2;

  typedef logic signed [SNN_W_WIDTH-1:0] weight_t;

  // Width needed to sum n_in signed weights without overflow.
  function automatic int acc_width(input int w_width, input int n_in);
    return w_width + $clog2(n_in) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int clamp_u(input int x, input int hi);
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

  localparam int SNN_ACC_W = acc_width(SNN_W_WIDTH, SNN_N_IN);
  localparam int SNN_MEM_W = SNN_V_WIDTH + 2;

endpackage

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, integrate, clamp, threshold.
// Optional refractory counter when SNN_REFRACTORY_EN is defined.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int V_WIDTH      = SNN_V_WIDTH,
  parameter int ACC_W        = SNN_ACC_W,
  parameter int THRESH       = SNN_THRESH,
  parameter int LEAK_SHIFT   = SNN_LEAK_SHIFT,
  parameter int REFRAC_TICKS = SNN_REFRAC_TICKS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic                    spike_o,
  output logic [V_WIDTH-1:0]      v_o
);

  localparam int SW = V_WIDTH + 2;

  if (THRESH >= (1 << V_WIDTH)) begin : g_bad_thresh
    $error("THRESH must be representable in V_WIDTH bits");
  end
  if (ACC_W >= SW) begin : g_bad_acc
    $error("accumulator wider than membrane arithmetic");
  end
  if (REFRAC_TICKS < 0) begin : g_bad_refrac
    $error("REFRAC_TICKS must be non-negative");
  end

  logic [V_WIDTH-1:0]   v_q, v_d, v_next;
  logic                 spike_q, spike_d;
  logic signed [SW-1:0] sum_s;

`ifdef SNN_REFRACTORY_EN
  localparam int RC_W = idx_width(REFRAC_TICKS + 1);
  logic [RC_W-1:0] rc_q, rc_d;
`endif

  // Two guard bits keep v - leak + acc exact before clamping.
  always_comb begin
    sum_s  = $signed({2'b00, v_q}) - $signed({2'b00, v_q >> LEAK_SHIFT})
           + $signed({{(SW-ACC_W){acc_i[ACC_W-1]}}, acc_i});
    v_next = V_WIDTH'(clamp_u(int'(sum_s), (1 << V_WIDTH) - 1));
  end

  always_comb begin
    v_d     = v_q;
    spike_d = 1'b0;
`ifdef SNN_REFRACTORY_EN
    rc_d    = rc_q;
`endif
    if (tick_i) begin
`ifdef SNN_REFRACTORY_EN
      if (rc_q != '0) begin
        rc_d = rc_q - RC_W'(1);
        v_d  = '0;
      end else
`endif
      if (v_next >= V_WIDTH'(THRESH)) begin
        spike_d = 1'b1;
        v_d     = '0;
`ifdef SNN_REFRACTORY_EN
        rc_d    = RC_W'(REFRAC_TICKS);
`endif
      end else begin
        v_d = v_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      spike_q <= 1'b0;
`ifdef SNN_REFRACTORY_EN
      rc_q    <= '0;
`endif
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
`ifdef SNN_REFRACTORY_EN
      rc_q    <= rc_d;
`endif
    end
  end

  assign spike_o = spike_q;
  assign v_o     = v_q;

endmodule

// File: rtl/snn_lif_layer.sv
// Fully-connected LIF layer: weight register file, synapse sums, debug mux.
// Refractory behaviour of the neurons is enabled by SNN_REFRACTORY_EN.
module snn_lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN         = SNN_N_IN,
  parameter int N_OUT        = SNN_N_OUT,
  parameter int W_WIDTH      = SNN_W_WIDTH,
  parameter int V_WIDTH      = SNN_V_WIDTH,
  parameter int THRESH       = SNN_THRESH,
  parameter int LEAK_SHIFT   = SNN_LEAK_SHIFT,
  parameter int REFRAC_TICKS = SNN_REFRAC_TICKS,
  localparam int N_W    = N_IN * N_OUT,
  localparam int ADDR_W = idx_width(N_W),
  localparam int DBG_W  = idx_width(N_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [N_IN-1:0]           spike_in,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic signed [W_WIDTH-1:0] cfg_wdata,
  input  logic [DBG_W-1:0]          dbg_sel,
  output logic [N_OUT-1:0]          spike_out,
  output logic [V_WIDTH-1:0]        dbg_v
);

  localparam int ACC_W = acc_width(W_WIDTH, N_IN);

  logic signed [W_WIDTH-1:0] w_q [N_W];
  logic signed [ACC_W-1:0]   acc [N_OUT];
  logic [V_WIDTH-1:0]        v_all [N_OUT];

  // A write landing with a tick only takes effect after that tick integrates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_W; k++) w_q[k] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < N_W)) begin
      w_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      acc[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (spike_in[i]) begin
          acc[j] = acc[j] + {{(ACC_W-W_WIDTH){w_q[j*N_IN+i][W_WIDTH-1]}}, w_q[j*N_IN+i]};
        end
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    snn_lif_neuron #(
      .V_WIDTH     (V_WIDTH),
      .ACC_W       (ACC_W),
      .THRESH      (THRESH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_TICKS(REFRAC_TICKS)
    ) u_neuron (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .acc_i  (acc[j]),
      .spike_o(spike_out[j]),
      .v_o    (v_all[j])
    );
  end

  always_comb begin
    dbg_v = '0;
    if (int'(dbg_sel) < N_OUT) dbg_v = v_all[dbg_sel];
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed plus randomized bench for snn_lif_layer against an integer model.
// Works with or without SNN_REFRACTORY_EN defined.
module tb_snn_lif_layer;
  import snn_pkg::*;

  localparam int N_IN = 3, N_OUT = 2, W_WIDTH = 4, V_WIDTH = 8;
  localparam int THRESH = 100, LEAK_SHIFT = 3, REFRAC_TICKS = 2;
  localparam int N_W = N_IN * N_OUT;
  localparam int ADDR_W = idx_width(N_W);
  localparam int DBG_W = idx_width(N_OUT);
`ifdef SNN_REFRACTORY_EN
  localparam bit REFRAC_EN = 1'b1;
`else
  localparam bit REFRAC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      tick = 1'b0;
  logic [N_IN-1:0]           spike_in = '0;
  logic                      cfg_we = 1'b0;
  logic [ADDR_W-1:0]         cfg_addr = '0;
  logic signed [W_WIDTH-1:0] cfg_wdata = '0;
  logic [DBG_W-1:0]          dbg_sel = '0;
  logic [N_OUT-1:0]          spike_out;
  logic [V_WIDTH-1:0]        dbg_v;

  snn_lif_layer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .spike_in (spike_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .dbg_sel  (dbg_sel),
    .spike_out(spike_out),
    .dbg_v    (dbg_v)
  );

  // ---------------- reference model + scoreboard ----------------
  int m_v [N_OUT];
  int m_r [N_OUT];
  int m_w [N_W];
  logic [N_OUT-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int j = 0; j < N_OUT; j++) begin m_v[j] = 0; m_r[j] = 0; end
    for (int k = 0; k < N_W; k++) m_w[k] = 0;
    exp_q.push_back('0);
  endtask

  task automatic model_step(input logic t, input logic [N_IN-1:0] s,
                            input logic we, input int addr, input int data);
    logic [N_OUT-1:0] fired;
    fired = '0;
    if (t) begin
      for (int j = 0; j < N_OUT; j++) begin
        int acc, nv;
        if (m_r[j] > 0) begin
          m_r[j] = m_r[j] - 1;
          m_v[j] = 0;
        end else begin
          acc = 0;
          for (int i = 0; i < N_IN; i++) if (s[i]) acc += m_w[j*N_IN+i];
          nv = m_v[j] - (m_v[j] / (1 << LEAK_SHIFT)) + acc;
          if (nv < 0) nv = 0;
          if (nv > (1 << V_WIDTH) - 1) nv = (1 << V_WIDTH) - 1;
          if (nv >= THRESH) begin
            fired[j] = 1'b1;
            m_v[j] = 0;
            m_r[j] = REFRAC_EN ? REFRAC_TICKS : 0;
          end else begin
            m_v[j] = nv;
          end
        end
      end
    end
    if (we && addr < N_W) m_w[addr] = data;
    exp_q.push_back(fired);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N_OUT-1:0] e;
    e = exp_q.pop_front();
    chk("spike_out", 32'(spike_out), 32'(e));
    for (int j = 0; j < N_OUT; j++) begin
      dbg_sel = DBG_W'(j);
      #1;
      chk($sformatf("dbg_v[%0d]", j), 32'(dbg_v), 32'(m_v[j]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic t, input logic [N_IN-1:0] s,
                       input logic we = 1'b0, input int addr = 0, input int data = 0);
    logic rst_at_edge;
    tick = t; spike_in = s; cfg_we = we;
    cfg_addr = ADDR_W'(addr); cfg_wdata = weight_t'(data);
    rst_at_edge = rst_n;
    @(posedge clk); #1;
    if (!rst_at_edge) model_reset();
    else model_step(t, s, we, addr, data);
    tick = 1'b0; cfg_we = 1'b0;
    check_outputs();
  endtask

  task automatic peek(input int n, output logic [V_WIDTH-1:0] v);
    dbg_sel = DBG_W'(n);
    #1;
    v = dbg_v;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [V_WIDTH-1:0] v;
    int fire_seq [7] = '{21, 40, 56, 70, 83, 94, 0};
    int pre, max_v, eq_spikes;

    model_reset();
    void'(exp_q.pop_front());

    // Reset held with tick, spikes and a weight write all active.
    rst_n = 1'b0;
    cycle(1'b1, 3'b111, 1'b1, 0, 7);
    cycle(1'b1, 3'b111, 1'b1, 1, 7);
    rst_n = 1'b1;

    for (int i = 0; i < N_IN; i++) cycle(1'b0, 3'b000, 1'b1, i, 7);

    // Integrate-and-fire on neuron 0.
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 3'b111);
      peek(0, v);
      chk($sformatf("fire_v0_t%0d", k + 1), 32'(v), 32'(fire_seq[k]));
      chk($sformatf("fire_spk_t%0d", k + 1), 32'(spike_out), (k == 6) ? 32'd1 : 32'd0);
    end

    // Ticks 8..10 after the spike.
    for (int k = 8; k <= 10; k++) begin
      cycle(1'b1, 3'b111);
      peek(0, v);
      if (REFRAC_EN) chk($sformatf("refrac_v0_t%0d", k), 32'(v), (k == 10) ? 32'd21 : 32'd0);
      else chk($sformatf("norefrac_v0_t%0d", k), 32'(v), (k == 8) ? 32'd21 : (k == 9) ? 32'd40 : 32'd56);
    end

    // Idle cycles hold membranes.
    repeat (3) cycle(1'b0, 3'b111);

    // Clamp at zero: v=5 then a -8 synapse.
    cycle(1'b0, 3'b000, 1'b1, 3, 5);
    cycle(1'b1, 3'b001);
    peek(1, v);
    chk("clamp_pre_v1", 32'(v), 32'd5);
    cycle(1'b0, 3'b000, 1'b1, 3, -8);
    cycle(1'b1, 3'b001);
    peek(1, v);
    chk("clamp_v1", 32'(v), 32'd0);

    // Weight write coinciding with a tick.
    pre = m_v[0];
    cycle(1'b1, 3'b001, 1'b1, 0, -1);
    peek(0, v);
    chk("collide_old_w", 32'(v), 32'(pre - pre / 8 + 7));
    pre = int'(v);
    cycle(1'b1, 3'b001);
    peek(0, v);
    chk("collide_new_w", 32'(v), 32'(pre - pre / 8 - 1));

    // Out-of-range addresses must not alias onto real weights.
    cycle(1'b0, 3'b000, 1'b1, 6, -8);
    cycle(1'b0, 3'b000, 1'b1, 7, -8);
    repeat (4) cycle(1'b1, 3'b111);

    // Reset mid-operation wins over tick and write, and clears weights.
    rst_n = 1'b0;
    cycle(1'b1, 3'b111, 1'b1, 0, 7);
    rst_n = 1'b1;
    cycle(1'b1, 3'b111);
    peek(0, v);
    chk("post_reset_v0", 32'(v), 32'd0);

    // Sub-threshold equilibrium with a single weight of 7.
    cycle(1'b0, 3'b000, 1'b1, 0, 7);
    max_v = 0; eq_spikes = 0;
    for (int k = 0; k < 200; k++) begin
      cycle(1'b1, 3'b001);
      peek(0, v);
      if (int'(v) > max_v) max_v = int'(v);
      if (spike_out[0]) eq_spikes++;
    end
    chk("equil_max_le_56", 32'(max_v <= 56), 32'd1);
    chk("equil_settled", 32'(v), 32'd56);
    chk("equil_no_spike", 32'(eq_spikes), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cycle(($urandom_range(0, 9) < 7), N_IN'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 3), $urandom_range(0, 7), $urandom_range(0, 15) - 8);
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
